// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : Parametrised register file with write-to-read bypass and a
//            per-register busy scoreboard for RAW hazard detection.
// Revision : 1.0
// ============================================================================
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]       rd_data,
    output logic [NRD-1:0]            rd_busy,
    input  logic [$clog2(NREGS)-1:0]  wr_addr,
    input  logic [XLEN-1:0]           wr_data,
    input  logic                      wr_en,
    input  logic [$clog2(NREGS)-1:0]  iss_addr,
    input  logic                      iss_en,
    output logic [$clog2(NREGS):0]    busy_cnt
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW:0] c_cnt_one = {{AW{1'b0}}, 1'b1};

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_busy_cnt;

    logic w_wr_hit;
    logic w_iss_hit;
    logic w_cnt_inc;
    logic w_cnt_dec;

    assign w_wr_hit  = wr_en  && (wr_addr  != '0);
    assign w_iss_hit = iss_en && (iss_addr != '0);

    // A same-address issue re-sets the bit, so the write-back clear never counts.
    assign w_cnt_inc = w_iss_hit && !r_busy[iss_addr];
    assign w_cnt_dec = w_wr_hit && r_busy[wr_addr] &&
                       !(w_iss_hit && (iss_addr == wr_addr));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wr_hit) begin
                r_regs[wr_addr] <= wr_data;
                r_busy[wr_addr] <= 1'b0;
            end
            if (w_iss_hit) begin
                r_busy[iss_addr] <= 1'b1;
            end
            case ({w_cnt_inc, w_cnt_dec})
                2'b10:   r_busy_cnt <= r_busy_cnt + c_cnt_one;
                2'b01:   r_busy_cnt <= r_busy_cnt - c_cnt_one;
                default: r_busy_cnt <= r_busy_cnt;
            endcase
        end
    end

    assign busy_cnt = r_busy_cnt;

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rd
            logic [AW-1:0]   w_addr;
            logic            w_fwd;
            logic [XLEN-1:0] w_data;
            logic            w_busy;

            assign w_addr = rd_addr[i*AW +: AW];

            if (BYPASS != 0) begin : g_byp
                assign w_fwd = w_wr_hit && (w_addr == wr_addr);
            end else begin : g_nobyp
                assign w_fwd = 1'b0;
            end

            always_comb begin
                w_data = r_regs[w_addr];
                w_busy = r_busy[w_addr];
                if (w_addr == '0) begin
                    w_data = '0;
                    w_busy = 1'b0;
                end else if (w_fwd) begin
                    w_data = wr_data;
                    w_busy = 1'b0;
                end
            end

            assign rd_data[i*XLEN +: XLEN] = w_data;
            assign rd_busy[i]              = w_busy;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Brief    : Self-checking bench: bypass and non-bypass instances vs. model.
// Revision : 1.0
// ============================================================================
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data_b, rd_data_n;
    logic [NRD-1:0]       rd_busy_b, rd_busy_n;
    logic [AW-1:0]        wr_addr;
    logic [XLEN-1:0]      wr_data;
    logic                 wr_en;
    logic [AW-1:0]        iss_addr;
    logic                 iss_en;
    logic [AW:0]          busy_cnt_b, busy_cnt_n;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) u_dut_byp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .iss_addr(iss_addr), .iss_en(iss_en), .busy_cnt(busy_cnt_b)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) u_dut_nobyp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .rd_busy(rd_busy_n), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .iss_addr(iss_addr), .iss_en(iss_en), .busy_cnt(busy_cnt_n)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int popcount();
        int n = 0;
        for (int k = 0; k < NREGS; k++) n += m_busy[k] ? 1 : 0;
        return n;
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0]   a;
            logic [XLEN-1:0] old_d;
            bit              old_b;
            bit              fwd;
            a     = rd_addr[i*AW +: AW];
            old_d = (a == 0) ? '0 : m_regs[a];
            old_b = (a == 0) ? 1'b0 : m_busy[a];
            fwd   = wr_en && (wr_addr != 0) && (a == wr_addr);
            check($sformatf("byp_data%0d", i),   64'(rd_data_b[i*XLEN +: XLEN]), 64'(fwd ? wr_data : old_d));
            check($sformatf("byp_busy%0d", i),   64'(rd_busy_b[i]),              64'(fwd ? 1'b0 : old_b));
            check($sformatf("nobyp_data%0d", i), 64'(rd_data_n[i*XLEN +: XLEN]), 64'(old_d));
            check($sformatf("nobyp_busy%0d", i), 64'(rd_busy_n[i]),              64'(old_b));
        end
        check("byp_cnt",   64'(busy_cnt_b), 64'(popcount()));
        check("nobyp_cnt", 64'(busy_cnt_n), 64'(popcount()));
    endtask

    task automatic model_update();
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                m_regs[k] = '0;
                m_busy[k] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic idle();
        rst_n  = 1'b1;
        wr_en  = 1'b0;
        iss_en = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NREGS; k++) begin
            m_regs[k] = '0;
            m_busy[k] = 1'b0;
        end
        rst_n = 1'b0; wr_en = 1'b0; iss_en = 1'b0;
        wr_addr = '0; wr_data = '0; iss_addr = '0; rd_addr = '0;
        @(posedge clk); #1;
        idle();

        // Reset overrides a simultaneous write
        rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEAD; set_rd(5, 0);
        cycle();
        idle(); #1;
        check("rst_rd5",  64'(rd_data_n[XLEN-1:0]), 64'd0);
        check("rst_busy", 64'(rd_busy_n), 64'd0);
        check("rst_cnt",  64'(busy_cnt_n), 64'd0);

        // Write / read, including a same-cycle forward
        wr_en = 1'b1; wr_addr = 1; wr_data = 123; set_rd(1, 1); #1;
        check("byp_r1_fwd", 64'(rd_data_b[XLEN-1:0]), 64'd123);
        check("nobyp_r1_old", 64'(rd_data_n[XLEN-1:0]), 64'd0);
        cycle();
        idle(); #1;
        check("r1_p0", 64'(rd_data_n[XLEN-1:0]), 64'd123);
        check("r1_p1", 64'(rd_data_n[2*XLEN-1:XLEN]), 64'd123);

        // Register 0 stays zero
        wr_en = 1'b1; wr_addr = 0; wr_data = 69; set_rd(0, 0); #1;
        check("r0_pre", 64'(rd_data_b), 64'd0);
        cycle();
        idle(); #1;
        check("r0_post", 64'(rd_data_b), 64'd0);

        // Bypass vs no bypass
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'h55; set_rd(7, 7); #1;
        check("byp_r7", 64'(rd_data_b[XLEN-1:0]), 64'h55);
        check("nobyp_r7_old", 64'(rd_data_n[XLEN-1:0]), 64'd0);
        cycle();
        idle(); #1;
        check("nobyp_r7_new", 64'(rd_data_n[XLEN-1:0]), 64'h55);

        // Scoreboard issue and write-back
        iss_en = 1'b1; iss_addr = 3; set_rd(3, 15);
        cycle();
        check("cnt_iss3", 64'(busy_cnt_b), 64'd1);
        iss_addr = 15;
        cycle();
        idle(); #1;
        check("cnt_iss15", 64'(busy_cnt_b), 64'd2);
        check("busy_3_15", 64'(rd_busy_n), 64'b11);
        wr_en = 1'b1; wr_addr = 3; wr_data = 99;
        cycle();
        idle(); #1;
        check("busy_after_wb", 64'(rd_busy_n), 64'b10);
        check("cnt_after_wb",  64'(busy_cnt_n), 64'd1);
        check("r3_data",       64'(rd_data_n[XLEN-1:0]), 64'd99);

        // Same-cycle issue + write to r4: idle first, then already busy
        wr_en = 1'b1; wr_addr = 4; wr_data = 44; iss_en = 1'b1; iss_addr = 4; set_rd(4, 4);
        cycle();
        idle(); #1;
        check("r4_idle_cnt",  64'(busy_cnt_n), 64'd2);
        check("r4_idle_busy", 64'(rd_busy_n[0]), 64'd1);
        wr_en = 1'b1; wr_addr = 4; wr_data = 45; iss_en = 1'b1; iss_addr = 4;
        cycle();
        idle(); #1;
        check("r4_busy_cnt",  64'(busy_cnt_n), 64'd2);
        check("r4_busy_data", 64'(rd_data_n[XLEN-1:0]), 64'd45);
        check("r4_busy_busy", 64'(rd_busy_n[0]), 64'd1);

        // Reset mid-operation with five busy registers
        for (int k = 0; k < 3; k++) begin
            iss_en = 1'b1; iss_addr = AW'(5 + k);
            wr_en  = 1'b1; wr_addr = AW'(20 + k); wr_data = 32'hA0 + 32'(k);
            cycle();
        end
        idle(); #1;
        check("pre_rst_cnt", 64'(busy_cnt_b), 64'd5);
        rst_n = 1'b0;
        cycle();
        idle();
        for (int a = 0; a < NREGS; a++) begin
            set_rd(a, NREGS - 1 - a); #1;
            check("mid_rst_data", 64'(rd_data_b), 64'd0);
            check("mid_rst_busy", 64'(rd_busy_b), 64'd0);
        end
        check("mid_rst_cnt", 64'(busy_cnt_b), 64'd0);
        iss_en = 1'b1; iss_addr = 2;
        cycle();
        idle(); #1;
        check("post_rst_iss", 64'(busy_cnt_b), 64'd1);

        // Randomised traffic, biased toward a few registers to force collisions
        for (int n = 0; n < 800; n++) begin
            bit narrow;
            narrow   = ($urandom_range(0, 1) == 1);
            rst_n    = ($urandom_range(0, 63) != 0);
            wr_en    = ($urandom_range(0, 2) != 0);
            iss_en   = ($urandom_range(0, 2) != 0);
            wr_addr  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            iss_addr = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wr_data  = $urandom;
            set_rd(narrow ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1),
                   narrow ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1));
            cycle();
        end
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file for the paVuk core. It generalises the fixed 2-read/1-write register file to configurable width, depth and read-port count, with optional write-to-read bypass. It adds a per-register busy scoreboard (set on issue, cleared on write-back) so the decode stage can detect RAW hazards. It sits between decode (read and issue ports) and write-back (write port).

Parameters:
XLEN, 32, data width in bits (8..64)
NREGS, 32, number of architectural registers, power of two, >= 2; register 0 hardwired to zero
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = no forwarding
AW (localparam), $clog2(NREGS), register address width

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  synchronous active-low reset
rd_addr  in  NRD*AW  packed read addresses; port i = bits [i*AW +: AW]
rd_data  out  NRD*XLEN  packed read data; port i = bits [i*XLEN +: XLEN]
rd_busy  out  NRD  scoreboard busy bit of each addressed register
wr_addr  in  AW  write-back address
wr_data  in  XLEN  write-back data
wr_en  in  1  write-back enable
iss_addr  in  AW  destination register of the instruction being issued
iss_en  in  1  issue enable; marks iss_addr busy
busy_cnt  out  AW+1  number of registers currently busy

Behaviour:
- Reset: at posedge clk with rst_n=0, all registers are set to 0, all busy bits to 0, and busy_cnt to 0. Reset overrides any wr_en or iss_en in the same cycle.
- Reads are combinational (zero latency) and independent per port.
  - rd_addr=0 always returns rd_data=0 and rd_busy=0.
- Write: at posedge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0 (unless overridden by issue, below).
  - wr_addr=0: no effect on data or busy state.
- Bypass, BYPASS=1: if wr_en=1, wr_addr!=0 and rd_addr[i]==wr_addr in the same cycle:
  - rd_data[i]=wr_data and rd_busy[i]=0, combinationally, before the edge.
  - Every matching port forwards.
- Bypass, BYPASS=0: rd_data[i] shows the old value until after the edge, and rd_busy[i] shows the current busy bit.
- Issue: at posedge with iss_en=1 and iss_addr!=0, busy[iss_addr] <= 1.
  - iss_addr=0 is ignored.
  - Issuing to an already-busy register is legal (WAW); the bit stays 1.
- Simultaneous write and issue to the same nonzero address: the data is written and the busy bit ends at 1 (the new producer wins).
- Simultaneous write and issue to different addresses: both take effect.
- busy_cnt is a registered count equal to popcount(busy) at all times after reset. Per edge:
  - +1 if issue sets a bit that was 0.
  - -1 if a write clears a bit that was 1 and issue does not re-set it.
  - Both events in one cycle → net change applied; same-address case: +1 if the bit was 0, else 0.
  - Never wraps: its maximum is NREGS-1 because register 0 is never busy.
- A write to a non-busy register is legal: the data updates and busy_cnt is unchanged.
- All state is flops (no reset-less memory) so the reset clears everything in one cycle.

Test Plan:
- Reset then read: rst_n=0 for one edge after wr_en=1/wr_addr=5/wr_data=0xDEAD → all ports read 0, rd_busy=0, busy_cnt=0.
- Write/read/x0: write 123 to r1, read r1 on ports 0 and 1 → 123/123; write 69 to r0 → r0 reads 0 on every port, before and after the edge.
- Bypass: BYPASS=1, wr_en=1 wr_addr=7 wr_data=0x55, rd_addr0=7 before the edge → rd_data0=0x55. BYPASS=0 → old value, then 0x55 one cycle later.
- Scoreboard: issue r3, then r15 → busy_cnt 1 then 2 and rd_busy set. Write r3=99 → rd_busy(r3)=0, busy_cnt=1, reads 99.
- Same-cycle issue+write to r4, r4 initially busy → r4 data updated, busy stays 1, busy_cnt unchanged. Same with r4 initially idle → busy=1, busy_cnt +1.
- Reset mid-operation: 5 registers busy with data written, rst_n=0 for one edge → busy_cnt=0, all rd_busy=0, all data 0. Issue r2 on the next edge → busy_cnt=1.
